// File: rtl/conv3x3_sram_master.sv
// conv3x3_sram_master: raster-scan 3x3 Laplacian engine driving two single-port SRAMs.
// Reads the source image with one-cycle latency, accumulates 8*centre - neighbours,
// clamps to 0..255 and writes every pixel (border pixels as 0) to the destination SRAM.
// Handshake: there is no valid/ready pair; start is a one-cycle request honoured only in
// IDLE, rd_q is sampled exactly one cycle after each rd_en, and done is a one-cycle pulse.
module conv3x3_sram_master #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic              rd_wen,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_q,
  output logic              wr_en,
  output logic              wr_wen,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_d,
  output logic [2:0]        dbg_state
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_ACC  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   c_q, c_d;
  logic [3:0]          tap_q, tap_d;
  logic signed [11:0]  acc_q, acc_d;
  logic                smp_q, smp_d;
  logic [3:0]          smp_tap_q, smp_tap_d;

  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic                wr_wen_q, wr_wen_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_d_q, wr_d_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Address of tap t (row-major over dy=-1..1, dx=-1..1) around centre c.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] c,
                                                  input logic [3:0] t);
    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] col_off;
    case (t)
      4'd0, 4'd1, 4'd2: row_off = '0;
      4'd3, 4'd4, 4'd5: row_off = W_A;
      default:          row_off = W_A + W_A;
    endcase
    case (t)
      4'd0, 4'd3, 4'd6: col_off = '0;
      4'd1, 4'd4, 4'd7: col_off = ADDR_W'(1);
      default:          col_off = ADDR_W'(2);
    endcase
    return c - W_A - ADDR_W'(1) + row_off + col_off;
  endfunction

  function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (x == '0) || (x == XW'(IMG_W - 1)) || (y == '0) || (y == YW'(IMG_H - 1));
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [11:0] v);
    if (v < 12'sd0)        return 8'd0;
    else if (v > 12'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

  // Contribution of the datum returning this cycle: centre weighs +8, neighbours -1.
  logic signed [11:0] samp;
  logic signed [11:0] acc_sum;
  always_comb begin
    samp = '0;
    if (smp_tap_q == 4'd4) samp = $signed({1'b0, rd_q, 3'b000});
    else                   samp = -$signed({4'b0000, rd_q});
    acc_sum = smp_q ? (acc_q + samp) : acc_q;
  end

  // Raster-order successor of the current pixel.
  logic          last_x, last_y, last_pix;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  always_comb begin
    last_x   = (x_q == XW'(IMG_W - 1));
    last_y   = (y_q == YW'(IMG_H - 1));
    last_pix = last_x && last_y;
    nx       = last_x ? '0 : (x_q + XW'(1));
    ny       = last_x ? (y_q + YW'(1)) : y_q;
  end

  // Next-state and registered-output decode; outputs are computed for the next state.
  logic              enter;
  logic [XW-1:0]     tgt_x;
  logic [YW-1:0]     tgt_y;
  logic [ADDR_W-1:0] tgt_c;
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    c_d       = c_q;
    tap_d     = tap_q;
    acc_d     = acc_sum;
    smp_d     = rd_en_q;
    smp_tap_d = tap_q - 4'd1;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_wen_d  = 1'b1;
    wr_addr_d = wr_addr_q;
    wr_d_d    = wr_d_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    enter     = 1'b0;
    tgt_x     = '0;
    tgt_y     = '0;
    tgt_c     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          enter = 1'b1;
        end
      end
      S_READ: begin
        busy_d = 1'b1;
        if (tap_q == 4'd9) begin
          state_d = S_ACC;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = tap_addr(c_q, tap_q);
          tap_d     = tap_q + 4'd1;
        end
      end
      S_ACC: begin
        busy_d    = 1'b1;
        state_d   = S_WR;
        wr_en_d   = 1'b1;
        wr_wen_d  = 1'b0;
        wr_addr_d = c_q;
        wr_d_d    = clamp8(acc_sum);
      end
      S_WR: begin
        if (last_pix) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          enter = 1'b1;
          tgt_x = nx;
          tgt_y = ny;
          tgt_c = c_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Start work on pixel (tgt_x, tgt_y): one zero write for a border, else the read burst.
    if (enter) begin
      x_d    = tgt_x;
      y_d    = tgt_y;
      c_d    = tgt_c;
      busy_d = 1'b1;
      if (is_border(tgt_x, tgt_y)) begin
        state_d   = S_WR;
        wr_en_d   = 1'b1;
        wr_wen_d  = 1'b0;
        wr_addr_d = tgt_c;
        wr_d_d    = 8'd0;
      end else begin
        state_d   = S_READ;
        rd_en_d   = 1'b1;
        rd_addr_d = tap_addr(tgt_c, 4'd0);
        tap_d     = 4'd1;
        acc_d     = '0;
      end
    end
  end

  // State, datapath and output registers; reset forces every output to its idle value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      c_q       <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      smp_q     <= 1'b0;
      smp_tap_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_wen_q  <= 1'b1;
      wr_addr_q <= '0;
      wr_d_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      c_q       <= c_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      smp_q     <= smp_d;
      smp_tap_q <= smp_tap_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_wen_q  <= wr_wen_d;
      wr_addr_q <= wr_addr_d;
      wr_d_q    <= wr_d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_wen    = 1'b1;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_wen    = wr_wen_q;
  assign wr_addr   = wr_addr_q;
  assign wr_d      = wr_d_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv3x3_sram_master.sv
// Testbench for conv3x3_sram_master on a 4x4 image with behavioural source/destination SRAMs.
module tb_conv3x3_sram_master;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 8;
  localparam int BUSY_CYC = 11 * (W - 2) * (H - 2) + 2 * W + 2 * (H - 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic          busy, done, rd_en, rd_wen, wr_en, wr_wen;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_q = 8'd0;
  logic [7:0]    wr_d;
  logic [2:0]    dbg_state;

  conv3x3_sram_master #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_q(rd_q),
    .wr_en(wr_en), .wr_wen(wr_wen), .wr_addr(wr_addr), .wr_d(wr_d),
    .dbg_state(dbg_state)
  );

  // ---------------- SRAM models ----------------
  logic [7:0] src_mem [N];
  logic [7:0] dst_mem [N];
  always @(posedge clk) if (rd_en && rd_wen) rd_q <= src_mem[rd_addr[3:0]];
  always @(posedge clk) if (wr_en && !wr_wen) dst_mem[wr_addr[3:0]] <= wr_d;

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [N*8-1:0] img;
    logic [N*8-1:0] exp;
    logic           use_model;
  } vec_t;
  vec_t tbl [5];

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic [N*8-1:0] fill(input logic [7:0] b);
    logic [N*8-1:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  function automatic logic [N*8-1:0] setb(input logic [N*8-1:0] v, input int idx, input logic [7:0] b);
    logic [N*8-1:0] r;
    r = v;
    r[idx*8 +: 8] = b;
    return r;
  endfunction

  // Golden Laplacian: border 0, interior 8*centre minus eight neighbours, clamped.
  function automatic logic [N*8-1:0] model(input logic [N*8-1:0] im);
    logic [N*8-1:0] r;
    int s;
    r = '0;
    for (int y = 1; y < H - 1; y++) begin
      for (int x = 1; x < W - 1; x++) begin
        s = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy == 0 && dx == 0) s += 8 * int'(im[(y*W+x)*8 +: 8]);
            else s -= int'(im[((y+dy)*W+x+dx)*8 +: 8]);
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        r[(y*W+x)*8 +: 8] = 8'(s);
      end
    end
    return r;
  endfunction

  // mode: 0 plain run, 1 plus cycle-exact trace, 2 start re-pulse at cycle ev, 3 reset at cycle ev
  task automatic run(input int vi, input int mode, input int ev);
    logic [N*8-1:0] expv;
    logic [15:0]    e;
    int rd_seq [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int busy_cnt = 0;
    int dst_bad = 0;
    bit ended = 1'b0;
    bit aborted = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_mem[i] = tbl[vi].img[i*8 +: 8];
      dst_mem[i] = 8'hEE;
    end
    expv = tbl[vi].use_model ? model(tbl[vi].img) : tbl[vi].exp;
    exp_q.delete();
    for (int a = 0; a < N; a++) exp_q.push_back({8'(a), expv[a*8 +: 8]});

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (wr_en) begin
        chk($sformatf("v%0d_wr_wen", vi), wr_wen, 0);
        if (exp_q.size() == 0) chk($sformatf("v%0d_extra_write", vi), wr_addr, 999);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d_wr_addr_data", vi), {wr_addr, wr_d}, e);
        end
      end
      if (rd_en && wr_en) chk("rd_wr_exclusive", 1, 0);
      if (mode == 1) begin
        if (n == 1) chk("first_busy", busy, 1);
        if (n >= 1 && n <= 5) chk($sformatf("trace_border_wr_n%0d", n), {wr_en, wr_addr}, {1'b1, 8'(n - 1)});
        if (n >= 6 && n <= 14) chk($sformatf("trace_rd_n%0d", n), {rd_en, rd_addr}, {1'b1, 8'(rd_seq[n-6])});
        if (n == 15) chk("trace_acc_cycle", {busy, rd_en, wr_en, dbg_state}, {3'b100, 3'd2});
        if (n == 16) chk("trace_wr5", {wr_en, wr_addr}, {1'b1, 8'd5});
      end
      if (mode == 2 && n == ev) start = 1'b1;
      if (mode == 2 && n == ev + 1) start = 1'b0;
      if (mode == 3 && n == ev) begin
        chk("abort_in_read", dbg_state, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {rd_en, rd_wen, rd_addr, wr_en, wr_wen, wr_addr, wr_d, busy, done},
            {1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0});
        aborted = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      else begin
        ended = 1'b1;
        break;
      end
    end

    if (aborted) begin
      repeat (2) begin
        @(negedge clk);
        chk("abort_hold_no_wr", wr_en, 0);
      end
      rst_n = 1'b1;
      exp_q.delete();
      repeat (10) begin
        @(negedge clk);
        chk("abort_no_restart", {busy, rd_en, wr_en, done}, 4'b0000);
      end
      return;
    end

    chk($sformatf("v%0d_busy_ended", vi), ended, 1);
    chk($sformatf("v%0d_done_after_busy", vi), done, 1);
    chk($sformatf("v%0d_busy_cycles", vi), busy_cnt, BUSY_CYC);
    @(negedge clk);
    chk($sformatf("v%0d_done_single", vi), {done, busy}, 2'b00);
    chk($sformatf("v%0d_sb_drained", vi), exp_q.size(), 0);
    for (int i = 0; i < N; i++) if (dst_mem[i] !== expv[i*8 +: 8]) dst_bad++;
    chk($sformatf("v%0d_dst_image_bad_bytes", vi), dst_bad, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [N*8-1:0] z;
    z = '0;
    tbl[0] = '{img: fill(8'd100), exp: z, use_model: 1'b0};
    tbl[1] = '{img: setb(z, 5, 8'd10), exp: setb(z, 5, 8'd80), use_model: 1'b0};
    tbl[2] = '{img: setb(z, 5, 8'd255), exp: setb(z, 5, 8'd255), use_model: 1'b0};
    tbl[3] = '{img: setb(fill(8'd255), 5, 8'd0),
               exp: setb(setb(setb(z, 6, 8'd255), 9, 8'd255), 10, 8'd255), use_model: 1'b0};
    tbl[4].img = '0;
    for (int i = 0; i < N; i++) tbl[4].img[i*8 +: 8] = 8'($urandom_range(0, 255));
    tbl[4].exp = '0;
    tbl[4].use_model = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_en, rd_wen, rd_addr, wr_en, wr_wen, wr_addr, wr_d, busy, done, dbg_state},
        {1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 3'd0});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {busy, done, rd_en, wr_en}, 4'b0000);

    run(0, 1, 0);
    for (int v = 1; v < 5; v++) run(v, 0, 0);
    run(1, 2, 20);
    run(4, 3, 20);
    run(4, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv3x3_sram_master.md
# conv3x3_sram_master

Raster-scan 3x3 Laplacian convolution engine that acts as the initiator on the single-port image SRAMs in the convolution datapath. After a `start` pulse it reads the gray-scale source image from one SRAM, with one-cycle read latency, and computes a clamped 3x3 Laplacian per pixel. It writes every result, border pixels included, into a second SRAM at the same address, then pulses `done`.

## Interface
- IMG_W, 256, image width in pixels.
- IMG_H, 128, image height in pixels.
- ADDR_W, 15, SRAM address width; IMG_W*IMG_H <= 2^ADDR_W.
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to process the whole image; ignored unless the FSM is in IDLE.
- busy  out  1  high in READ/ACC/WR states.
- done  out  1  one-cycle pulse after the final write.
- rd_en  out  1  source SRAM enable.
- rd_wen  out  1  source SRAM write-enable, active-low; constant 1.
- rd_addr  out  ADDR_W  source address.
- rd_q  in  8  source data, valid the cycle after rd_en.
- wr_en  out  1  destination SRAM enable.
- wr_wen  out  1  destination write-enable, active-low; 0 only together with wr_en=1.
- wr_addr  out  ADDR_W  destination address.
- wr_d  out  8  destination write data.

## Operation
- Pixel (x,y) lives at address y*IMG_W+x.
- Scan order is raster: y outer 0..IMG_H-1, x inner 0..IMG_W-1.
- Border pixel (x=0, x=IMG_W-1, y=0 or y=IMG_H-1): a single WR cycle writes 0 and no reads are issued.
- Interior pixel read sequence: 9 reads, row-major, dy=-1..1 outer and dx=-1..1 inner, address = c + dy*IMG_W + dx.
- Interior pixel result: out = 8*p(0,0) - sum of the 8 neighbours.
- Accumulator width: 12-bit signed (range -2040..2040).
- Clamp: results below 0 write 0; results above 255 write 255.
- FSM states:
  - IDLE: start=1 -> WR if the first pixel is a border, else READ.
  - READ: 9 cycles, each with rd_en=1 and the next address. The read issued in READ cycle k returns in the following cycle and is accumulated there. After the 9th read -> ACC.
  - ACC: 1 cycle; accumulates the 9th datum. -> WR.
  - WR: 1 cycle; wr_en=1, wr_wen=0, wr_addr=c, wr_d=clamped result (or 0 for a border pixel). Advances x/y. -> DONE after the last pixel; else READ or WR depending on whether the next pixel is interior or border.
  - DONE: 1 cycle; done=1, busy=0. -> IDLE.
- The accumulator clears on entry to READ.
- rd_en and wr_en are never high in the same cycle.
- Reset values: rd_en=0, rd_wen=1, rd_addr=0, wr_en=0, wr_wen=1, wr_addr=0, wr_d=0, busy=0, done=0; FSM in IDLE, x=y=0.
- Outputs outside their active states: rd_en=0, wr_en=0, wr_wen=1.

## Timing
- All outputs are registered.
- Cost per pixel: interior = 11 cycles (9 READ + ACC + WR); border = 1 cycle.
- With start sampled high in IDLE at edge T:
  - first active state begins at T+1, with busy=1;
  - busy stays high for exactly 11*(IMG_W-2)*(IMG_H-2) + 2*IMG_W + 2*(IMG_H-2) cycles;
  - done=1 in the following cycle.
- start while busy or in DONE is ignored; it does not restart and does not queue.
- rst_n low mid-operation: all outputs take their reset values immediately. No partial write completes after the assertion. A new start is required after release.
- The source SRAM contract is one-cycle read latency with data held until the next enabled access. The engine samples rd_q only in the cycle after each rd_en.

## Test plan
- Uniform image, IMG_W=IMG_H=4, all pixels 100 -> all 16 destination bytes = 0; busy high for exactly 56 cycles; single done pulse.
- Same size, start at T -> border writes at addresses 0..4 on cycles T+1..T+5; rd_addr = 0,1,2,4,5,6,8,9,10 on T+6..T+14; ACC at T+15; WR of address 5 at T+16.
- Impulse: pixel (1,1)=10, rest 0, 4x4 -> out(1,1)=80; out(2,1), out(1,2), out(2,2)=0 (clamped from -10); all borders 0.
- Saturation: centre (1,1)=255, neighbours 0 -> writes 255; centre 0 with 8 neighbours 255 -> writes 0.
- start re-pulsed at T+20 while busy -> no effect; total cycle count and written data are identical to the single-start run.
- rst_n pulsed low at T+20 (during a READ) -> outputs return to reset values asynchronously; no wr_en afterwards. A fresh start then completes a full run in 56 cycles with correct results.
